load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_if.sv | 31 +++
 rtl/load_store_unit.sv | 108 ++++++++++
 2 files changed

// File: rtl/load_store_unit_if.sv
// Core request/response and data-memory signals of the load/store unit.
// slave: the unit itself; master: the core plus the attached memory.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Byte/half/word load-store unit; response 1 (error), 2 (sw), 3 (load) or 4 (sb/sh RMW) cycles after accept.
// One access in flight: req_ready only in IDLE, requests presented while busy are ignored.
module load_store_unit #(
  parameter int DEPTH_WORDS = 64
) (
  input  logic               clk,
  input  logic               rst,
  load_store_unit_if.slave   bus
);

  typedef enum logic [2:0] {IDLE, RD, RDW, WR, RESP} state_t;

  state_t      state, state_nxt;
  logic        we_q, uns_q, err_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic        accept, req_err;
  logic [4:0]  sh;
  logic [31:0] lane_data, load_ext, merged;

  assign accept = bus.req_valid && bus.req_ready;

  always_comb begin
    req_err = 1'b0;
    case (bus.req_size)
      2'b01:   req_err = bus.req_addr[0];
      2'b10:   req_err = |bus.req_addr[1:0];
      2'b11:   req_err = 1'b1;
      default: req_err = 1'b0;
    endcase
    if ({2'b00, bus.req_addr[31:2]} >= 32'(DEPTH_WORDS))
      req_err = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Sub-word stores take the read path first so the untouched lanes can be merged.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) begin
        if (req_err)                                  state_nxt = RESP;
        else if (!bus.req_we || bus.req_size != 2'b10) state_nxt = RD;
        else                                           state_nxt = WR;
      end
      RD:      state_nxt = RDW;
      RDW:     state_nxt = we_q ? WR : RESP;
      WR:      state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready  = (state == IDLE) && rst;
    bus.mem_read   = (state == RD);
    bus.mem_write  = (state == WR);
    bus.mem_wdata  = (state == WR) ? wdata_q : 32'd0;
    bus.mem_addr   = {2'b00, addr_q[31:2]};
    bus.resp_valid = (state == RESP);
    bus.resp_err   = (state == RESP) && err_q;
    bus.resp_rdata = rdata_q;
  end

  assign sh        = {addr_q[1:0], 3'b000};
  assign lane_data = bus.mem_rdata >> sh;

  always_comb begin
    case (size_q)
      2'b00:   load_ext = {{24{lane_data[7]  & ~uns_q}}, lane_data[7:0]};
      2'b01:   load_ext = {{16{lane_data[15] & ~uns_q}}, lane_data[15:0]};
      default: load_ext = bus.mem_rdata;
    endcase
    case (size_q)
      2'b00:   merged = (bus.mem_rdata & ~(32'h0000_00FF << sh)) | ({24'd0, wdata_q[7:0]}  << sh);
      2'b01:   merged = (bus.mem_rdata & ~(32'h0000_FFFF << sh)) | ({16'd0, wdata_q[15:0]} << sh);
      default: merged = wdata_q;
    endcase
  end

  // rdata_q is cleared at accept so stores and errors respond with zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
    end else if (accept) begin
      we_q    <= bus.req_we;
      uns_q   <= bus.req_unsigned;
      err_q   <= req_err;
      size_q  <= bus.req_size;
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
      rdata_q <= 32'd0;
    end else if (state == RDW) begin
      if (we_q) wdata_q <= merged;
      else      rdata_q <= load_ext;
    end
  end

endmodule
